// File: rtl/lsu_wb.sv
// Load/writeback stage: accepts one executed instruction, performs an optional
// word-aligned memory read with byte/halfword extraction, and writes the register file once.
// Optional misaligned-load trap enabled by defining LSU_WB_MISALIGN_CHECK_EN.
module lsu_wb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_alu,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WB
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   rd_q;
    logic                    wen_q;
    logic [2:0]              funct3_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;
    logic [DATA_WIDTH-1:0]   ext_data;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic                    mis_in;
    logic                    mis_q;

`ifdef LSU_WB_MISALIGN_CHECK_EN
    // Halfword loads need addr[0]==0, word loads need addr[1:0]==0.
    always_comb begin
        mis_in = 1'b0;
        if (in_is_load) begin
            case (in_funct3)
                3'b001, 3'b101: mis_in = in_addr[0];
                3'b010:         mis_in = (in_addr[1:0] != 2'b00);
                default:        mis_in = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            mis_q <= mis_in;
        end
    end
`else
    assign mis_in = 1'b0;
    assign mis_q  = 1'b0;
`endif

    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rsp_data[7:0];
            2'd1: byte_sel = mem_rsp_data[15:8];
            2'd2: byte_sel = mem_rsp_data[23:16];
            2'd3: byte_sel = mem_rsp_data[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        case (funct3_q)
            3'b000:  ext_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b001:  ext_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  ext_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: ext_data = mem_rsp_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        rf_wen        = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (in_is_load && !mis_in) ? REQ : WB;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                done      = 1'b1;
                err       = mis_q;
                rf_wen    = wen_q && (rd_q != '0) && !mis_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // wb_data_q holds the ALU result from accept and is overwritten by load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= '0;
            wen_q     <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wb_data_q <= '0;
        end else if (state == IDLE && in_valid) begin
            rd_q      <= in_rd;
            wen_q     <= in_wen;
            funct3_q  <= in_funct3;
            addr_q    <= in_addr;
            wb_data_q <= in_alu;
        end else if (state == WAIT && mem_rsp_valid) begin
            wb_data_q <= ext_data;
        end
    end

    assign mem_req_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign rf_waddr     = rd_q;
    assign rf_wdata     = wb_data_q;

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/writeback stage that sits directly upstream of the register file. It accepts one executed instruction at a time over a valid/ready handshake. For loads it issues a single word-aligned memory read, waits for the response, then extracts and extends the addressed byte, halfword or word. It then drives the register file's write port (`rf_wen`/`rf_waddr`/`rf_wdata`) for exactly one cycle per retired instruction.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: register index width; matches the register file write address.
- `DATA_WIDTH`, 32: datapath width; memory and register data.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock; all state updates on its rising edge.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Instruction input (valid/ready):
  - `in_valid`  in  1  instruction from execute is valid.
  - `in_ready`  out  1  stage can accept an instruction.
  - `in_rd`  in  ADDR_WIDTH  destination register.
  - `in_wen`  in  1  instruction writes `in_rd`.
  - `in_is_load`  in  1  instruction is a load.
  - `in_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - `in_addr`  in  DATA_WIDTH  load effective address.
  - `in_alu`  in  DATA_WIDTH  result for non-loads.
- Memory request and response:
  - `mem_req_valid`  out  1  read request valid.
  - `mem_req_ready`  in  1  memory accepts the request.
  - `mem_req_addr`  out  DATA_WIDTH  request address = {`in_addr`[31:2], 2'b00} (latched).
  - `mem_rsp_valid`  in  1  read data valid.
  - `mem_rsp_data`  in  DATA_WIDTH  read word.
- Register file write port:
  - `rf_wen`  out  1  register file write enable.
  - `rf_waddr`  out  ADDR_WIDTH  register file write address.
  - `rf_wdata`  out  DATA_WIDTH  register file write data.
- Status:
  - `done`  out  1  one-cycle pulse when an instruction retires.
  - `err`  out  1  misaligned-load flag; tied 0 unless the macro below is defined.

## Operation
States:
- IDLE: `in_ready`=1. On `in_valid`, latch all `in_*` fields. Next state is REQ if `in_is_load`, otherwise WB.
- REQ: `mem_req_valid`=1. On `mem_req_ready`, go to WAIT. Otherwise hold REQ with address stable.
- WAIT: on `mem_rsp_valid`, register the extracted data and go to WB. `mem_rsp_valid` in any other state is ignored.
- WB:
  - `rf_wen` = latched `wen` && `rd`≠0.
  - `rf_waddr` = latched `rd`.
  - `rf_wdata` = load data or latched `alu`.
  - `done`=1.
  - Next state is always IDLE.

Extraction, with `off` = latched `addr`[1:0]:
- LB/LBU: byte `off`, sign-/zero-extended.
- LH/LHU: halfword `addr`[1], sign-/zero-extended.
- LW and funct3 011/110/111: full word.

General rules:
- Exactly one register write per accepted instruction with `wen` and `rd`≠0; no write otherwise.
- All outputs are driven from state/latched registers only; there is no combinational path from `in_*` or `mem_rsp_*` to outputs.

Reset:
- Asynchronous assert forces IDLE.
- `in_ready`=1 (IDLE value); `mem_req_valid`, `rf_wen`, `done`, `err`=0; `rf_waddr`, `rf_wdata`, `mem_req_addr`=0.
- Reset mid-operation abandons the instruction with no write. A late response is ignored.

## Timing
- Non-load: accepted at edge t0, WB during cycle t0+1, `in_ready` high again at t0+2. Back-to-back throughput is 1 instruction per 2 cycles.
- Load: accepted t0, REQ t0+1; with `mem_req_ready` at t0+1, WAIT t0+2. With `mem_rsp_valid` at t0+2, WB t0+3. Minimum load latency is 3 cycles to write.
- Each stall cycle of `mem_req_ready` or `mem_rsp_valid` adds one cycle.
- `mem_req_valid` never drops before `mem_req_ready` is seen; `mem_req_addr` is stable while `mem_req_valid` is high.
- `in_ready`=0 in REQ, WAIT and WB; `in_valid` is ignored there.

## Configuration
- `LSU_WB_MISALIGN_CHECK_EN` defined:
  - A load is misaligned when it is LH/LHU with `addr`[0]=1, or LW with `addr`[1:0]≠0.
  - A misaligned load skips REQ/WAIT and goes IDLE→WB.
  - In that WB cycle: `rf_wen`=0, `err`=1, `done`=1.
- Undefined:
  - `err` is tied 0.
  - Low address bits not used by extraction are ignored; the load proceeds normally.

## Test plan
- Non-load: `in_alu`=0x1234_5678, `in_rd`=5, `in_wen`=1 accepted at t0 → `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234_5678 at t0+1, `done` pulse.
- LB at `in_addr`=0x8000_0003, `mem_rsp_data`=0x80FF_FFFF → `mem_req_addr`=0x8000_0000, `rf_wdata`=0xFFFF_FF80. Same address with LBU → 0x0000_0080.
- LHU at 0x8000_0002, data 0xBEEF_0000, `mem_req_ready` held low 3 cycles and `mem_rsp_valid` delayed 2 cycles → address stable throughout, `rf_wdata`=0x0000_BEEF, write at t0+8.
- Non-load with `in_rd`=0, `in_wen`=1 → `done`=1 with `rf_wen`=0. Spurious `mem_rsp_valid` in IDLE → no effect.
- `rst_n` asserted during WAIT, then response arrives after release → no `rf_wen`, state IDLE, `in_ready`=1.
- LW at 0x8000_0002: with the macro → `err`=1, no request, no write. Without the macro → request to 0x8000_0000, full word written.
